// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op encoding widths/bit positions and the EXE stage state encoding.
package cpu_pkg;

  localparam int ALU_OP_W    = 16;
  localparam int ALU_OP_DIV  = 14;
  localparam int ALU_OP_DIVU = 15;

  typedef enum logic [2:0] {
    ES_EMPTY    = 3'd0,
    ES_HOLD     = 3'd1,
    ES_DIV_BUSY = 3'd2,
    ES_DIV_DONE = 3'd3,
    ES_DRAIN    = 3'd4
  } es_state_e;

  function automatic logic is_div_op(input logic [ALU_OP_W-1:0] op);
    return op[ALU_OP_DIV] | op[ALU_OP_DIVU];
  endfunction

endpackage

// File: rtl/exe_stage.sv
// EXE pipeline stage control: holds one instruction, drives the sibling ALU, waits for divider
// completion and hands the result to MEM over a valid/allowin handshake.
module exe_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DIV_WATCHDOG = 64
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ds_to_es_valid,
  output logic                es_allowin,
  input  logic [ALU_OP_W-1:0] ds_alu_op,
  input  logic                ds_is_upper,
  input  logic [31:0]         ds_src1,
  input  logic [31:0]         ds_src2,
  input  logic [4:0]          ds_dest,
  input  logic                ds_rf_we,
  input  logic [31:0]         ds_pc,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                is_upper,
  output logic [31:0]         alu_src1,
  output logic [31:0]         alu_src2,
  output logic                alu_issue,
  input  logic [31:0]         alu_result,
  input  logic                div_valid,
  input  logic                divu_valid,
  output logic                es_to_ms_valid,
  input  logic                ms_allowin,
  output logic [31:0]         es_result,
  output logic [4:0]          es_dest,
  output logic                es_rf_we,
  output logic [31:0]         es_pc,
  output logic                es_fwd_valid,
  output logic [4:0]          es_busy_dest,
  input  logic                flush,
  output logic                div_timeout
);

  localparam int WD_W = $clog2(DIV_WATCHDOG + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(DIV_WATCHDOG);

  es_state_e             state_q, state_d;
  logic [ALU_OP_W-1:0]   op_q;
  logic                  upper_q;
  logic [31:0]           src1_q, src2_q, pc_q;
  logic [4:0]            dest_q;
  logic                  rf_we_q;
  logic [31:0]           div_q, div_d;
  logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;
  logic                  timeout_q, timeout_d;

  logic      accept, done, wd_active, holding;
  es_state_e accept_state;

  assign holding   = (state_q == ES_HOLD) || (state_q == ES_DIV_DONE);
  assign wd_active = (state_q == ES_DIV_BUSY) || (state_q == ES_DRAIN);
  assign done      = (op_q[ALU_OP_DIV] & div_valid) | (op_q[ALU_OP_DIVU] & divu_valid);

  assign es_allowin   = (state_q == ES_EMPTY) || (holding && ms_allowin);
  assign accept       = ds_to_es_valid & es_allowin & ~flush;
  assign accept_state = is_div_op(ds_alu_op) ? ES_DIV_BUSY : ES_HOLD;

  // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    wd_cnt_d  = '0;
    timeout_d = 1'b0;

    case (state_q)
      ES_EMPTY: begin
        if (accept) state_d = accept_state;
      end
      ES_HOLD, ES_DIV_DONE: begin
        if (flush)           state_d = ES_EMPTY;
        else if (ms_allowin) state_d = accept ? accept_state : ES_EMPTY;
      end
      ES_DIV_BUSY: begin
        // The done pulse is captured unconditionally; MEM backpressure only delays delivery.
        if (done) begin
          div_d   = alu_result;
          state_d = flush ? ES_EMPTY : ES_DIV_DONE;
        end else if (flush) begin
          state_d = ES_DRAIN;
        end
      end
      ES_DRAIN: begin
        if (done) state_d = ES_EMPTY;
      end
      default: state_d = ES_EMPTY;
    endcase

    if (wd_active) begin
      wd_cnt_d  = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + WD_W'(1);
      timeout_d = (wd_cnt_q != WD_MAX) && (wd_cnt_q + WD_W'(1) == WD_MAX);
    end
  end

  // NOTE: reset is synchronous and active-low, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ES_EMPTY;
      op_q      <= '0;
      upper_q   <= 1'b0;
      src1_q    <= '0;
      src2_q    <= '0;
      dest_q    <= '0;
      rf_we_q   <= 1'b0;
      pc_q      <= '0;
      div_q     <= '0;
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q   <= state_d;
      div_q     <= div_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
      if (accept) begin
        op_q    <= ds_alu_op;
        upper_q <= ds_is_upper;
        src1_q  <= ds_src1;
        src2_q  <= ds_src2;
        dest_q  <= ds_dest;
        rf_we_q <= ds_rf_we;
        pc_q    <= ds_pc;
      end
    end
  end

  // DRAIN keeps the divide op visible so the ALU holds its sent-flag until the orphan pulse.
  assign alu_op    = (state_q == ES_EMPTY) ? '0 : op_q;
  assign is_upper  = upper_q;
  assign alu_src1  = src1_q;
  assign alu_src2  = src2_q;
  assign alu_issue = (state_q == ES_HOLD) || (state_q == ES_DIV_BUSY) || (state_q == ES_DRAIN);

  always_comb begin
    es_result = '0;
    if (state_q == ES_HOLD)          es_result = alu_result;
    else if (state_q == ES_DIV_DONE) es_result = div_q;
  end

  assign es_to_ms_valid = holding;
  assign es_dest        = dest_q;
  assign es_pc          = pc_q;
  assign es_rf_we       = rf_we_q && (holding || (state_q == ES_DIV_BUSY));
  assign es_fwd_valid   = holding && rf_we_q;
  assign es_busy_dest   = ((state_q == ES_DIV_BUSY) && rf_we_q) ? dest_q : 5'd0;
  assign div_timeout    = timeout_q;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed scenarios plus a randomized pipeline run
// against an occupancy/queue-level reference model.
module tb_exe_stage;

  localparam logic [15:0] OP_ADD  = 16'h0001;
  localparam logic [15:0] OP_SUB  = 16'h0002;
  localparam logic [15:0] OP_OR   = 16'h0004;
  localparam logic [15:0] OP_DIV  = 16'h4000;
  localparam logic [15:0] OP_DIVU = 16'h8000;

  logic        clk, resetn;
  logic        ds_to_es_valid, es_allowin;
  logic [15:0] ds_alu_op, alu_op;
  logic        ds_is_upper, is_upper;
  logic [31:0] ds_src1, ds_src2, ds_pc;
  logic [4:0]  ds_dest;
  logic        ds_rf_we;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic        alu_issue, div_valid, divu_valid;
  logic        es_to_ms_valid, ms_allowin;
  logic [31:0] es_result, es_pc;
  logic [4:0]  es_dest, es_busy_dest;
  logic        es_rf_we, es_fwd_valid, flush, div_timeout;

  int checks = 0;
  int failures = 0;

  exe_stage #(.DIV_WATCHDOG(64)) dut (
    .clk(clk), .resetn(resetn),
    .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
    .ds_alu_op(ds_alu_op), .ds_is_upper(ds_is_upper),
    .ds_src1(ds_src1), .ds_src2(ds_src2), .ds_dest(ds_dest),
    .ds_rf_we(ds_rf_we), .ds_pc(ds_pc),
    .alu_op(alu_op), .is_upper(is_upper), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_issue(alu_issue), .alu_result(alu_result),
    .div_valid(div_valid), .divu_valid(divu_valid),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_result(es_result), .es_dest(es_dest), .es_rf_we(es_rf_we), .es_pc(es_pc),
    .es_fwd_valid(es_fwd_valid), .es_busy_dest(es_busy_dest),
    .flush(flush), .div_timeout(div_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [15:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_OR:   return a | b;
      OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return 32'h0;
    endcase
  endfunction

  // Sibling ALU: divide results are only meaningful while the done pulse is up.
  always_comb begin
    alu_result = ref_alu(alu_op, alu_src1, alu_src2);
    if ((alu_op == OP_DIV || alu_op == OP_DIVU) && !(div_valid || divu_valid))
      alu_result = 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic offer(input logic [15:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dest, input logic we, input logic [31:0] pc);
    ds_to_es_valid = 1'b1;
    ds_alu_op      = op;
    ds_src1        = a;
    ds_src2        = b;
    ds_dest        = dest;
    ds_rf_we       = we;
    ds_pc          = pc;
  endtask

  initial begin
    #500000;
    $display("FAIL tb_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int bad;
    int pulses;
    bit occ;
    logic [31:0] m_res, m_pc;
    logic [4:0]  m_dest;
    logic        allow_exp;

    resetn = 1'b0; ds_to_es_valid = 1'b0; ds_alu_op = '0; ds_is_upper = 1'b0;
    ds_src1 = '0; ds_src2 = '0; ds_dest = '0; ds_rf_we = 1'b0; ds_pc = '0;
    div_valid = 1'b0; divu_valid = 1'b0; ms_allowin = 1'b1; flush = 1'b0;
    repeat (2) tick();
    settle();
    check("rst_allowin", es_allowin, 1);
    check("rst_valid", es_to_ms_valid, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_issue", alu_issue, 0);
    check("rst_result", es_result, 0);
    check("rst_timeout", div_timeout, 0);
    resetn = 1'b1;
    tick();

    // Single ADD
    offer(OP_ADD, 5, 7, 5'd3, 1'b1, 32'h100);
    ds_is_upper = 1'b1;
    settle();
    check("add_allowin_empty", es_allowin, 1);
    tick();
    ds_to_es_valid = 1'b0;
    ds_is_upper = 1'b0;
    settle();
    check("add_valid", es_to_ms_valid, 1);
    check("add_result", es_result, 12);
    check("add_allowin_hold", es_allowin, 1);
    check("add_dest", es_dest, 3);
    check("add_pc", es_pc, 32'h100);
    check("add_fwd", es_fwd_valid, 1);
    check("add_upper", is_upper, 1);
    check("add_src2", alu_src2, 7);
    tick();
    settle();
    check("add_drained", es_to_ms_valid, 0);

    // DIV with a 34-cycle latency
    offer(OP_DIV, 100, 7, 5'd5, 1'b1, 32'h104);
    tick();
    ds_to_es_valid = 1'b0;
    bad = 0;
    repeat (34) begin
      settle();
      if (es_allowin !== 1'b0 || es_busy_dest !== 5'd5 || es_to_ms_valid !== 1'b0 ||
          alu_issue !== 1'b1 || div_timeout !== 1'b0) bad++;
      tick();
    end
    check("div_busy_cycles_bad", bad, 0);
    div_valid = 1'b1;
    tick();
    div_valid = 1'b0;
    settle();
    check("div_result", es_result, 14);
    check("div_done_issue", alu_issue, 0);
    check("div_done_valid", es_to_ms_valid, 1);
    check("div_done_busy_dest", es_busy_dest, 0);
    tick();
    settle();
    check("div_drained", es_to_ms_valid, 0);

    // DIVU completes under MEM backpressure
    ms_allowin = 1'b0;
    offer(OP_DIVU, 32'hFFFF_FFFF, 3, 5'd9, 1'b1, 32'h108);
    tick();
    ds_to_es_valid = 1'b0;
    repeat (3) tick();
    divu_valid = 1'b1;
    tick();
    divu_valid = 1'b0;
    bad = 0;
    repeat (5) begin
      settle();
      if (es_to_ms_valid !== 1'b1 || es_result !== 32'h5555_5555 || es_allowin !== 1'b0) bad++;
      tick();
    end
    check("divu_held_bad", bad, 0);
    ms_allowin = 1'b1;
    settle();
    check("divu_deliver_valid", es_to_ms_valid, 1);
    check("divu_deliver_result", es_result, 32'h5555_5555);
    check("divu_deliver_allowin", es_allowin, 1);
    tick();
    settle();
    check("divu_once", es_to_ms_valid, 0);

    // Flush a DIV in its third busy cycle
    offer(OP_DIV, 50, 5, 5'd7, 1'b1, 32'h10C);
    tick();
    ds_to_es_valid = 1'b0;
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bad = 0;
    repeat (4) begin
      settle();
      if (es_to_ms_valid !== 1'b0 || es_allowin !== 1'b0 || alu_issue !== 1'b1 ||
          alu_op !== OP_DIV || es_rf_we !== 1'b0 || es_busy_dest !== 5'd0) bad++;
      tick();
    end
    check("drain_bad", bad, 0);
    div_valid = 1'b1;
    settle();
    check("drain_allowin_on_pulse", es_allowin, 0);
    tick();
    div_valid = 1'b0;
    settle();
    check("drain_exit_allowin", es_allowin, 1);
    check("drain_exit_valid", es_to_ms_valid, 0);
    offer(OP_ADD, 20, 22, 5'd2, 1'b1, 32'h110);
    tick();
    ds_to_es_valid = 1'b0;
    settle();
    check("post_drain_valid", es_to_ms_valid, 1);
    check("post_drain_result", es_result, 42);
    tick();

    // Flush coinciding with the done pulse goes straight to empty
    offer(OP_DIV, 9, 3, 5'd8, 1'b1, 32'h114);
    tick();
    ds_to_es_valid = 1'b0;
    flush = 1'b1;
    div_valid = 1'b1;
    tick();
    flush = 1'b0;
    div_valid = 1'b0;
    settle();
    check("flush_done_allowin", es_allowin, 1);
    check("flush_done_valid", es_to_ms_valid, 0);
    check("flush_done_issue", alu_issue, 0);

    // Flush blocks acceptance
    offer(OP_ADD, 1, 1, 5'd1, 1'b1, 32'h118);
    flush = 1'b1;
    tick();
    ds_to_es_valid = 1'b0;
    flush = 1'b0;
    settle();
    check("flush_blocks_valid", es_to_ms_valid, 0);
    check("flush_blocks_issue", alu_issue, 0);

    // Back-to-back ADD, SUB, OR
    offer(OP_ADD, 1, 2, 5'd1, 1'b1, 32'h200);
    tick();
    offer(OP_SUB, 10, 3, 5'd2, 1'b1, 32'h204);
    settle();
    check("b2b_add", es_result, 3);
    check("b2b_add_pc", es_pc, 32'h200);
    tick();
    offer(OP_OR, 32'hF0, 32'h0F, 5'd3, 1'b1, 32'h208);
    settle();
    check("b2b_sub_valid", es_to_ms_valid, 1);
    check("b2b_sub", es_result, 7);
    check("b2b_sub_pc", es_pc, 32'h204);
    tick();
    ds_to_es_valid = 1'b0;
    settle();
    check("b2b_or_valid", es_to_ms_valid, 1);
    check("b2b_or", es_result, 32'hFF);
    check("b2b_or_pc", es_pc, 32'h208);
    tick();
    settle();
    check("b2b_empty", es_to_ms_valid, 0);

    // Reset in the middle of a divide
    offer(OP_DIV, 8, 2, 5'd4, 1'b1, 32'h300);
    tick();
    ds_to_es_valid = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    settle();
    check("midrst_allowin", es_allowin, 1);
    check("midrst_valid", es_to_ms_valid, 0);
    check("midrst_alu_op", alu_op, 0);
    check("midrst_issue", alu_issue, 0);
    check("midrst_busy_dest", es_busy_dest, 0);
    check("midrst_pc", es_pc, 0);
    check("midrst_src1", alu_src1, 0);
    check("midrst_rf_we", es_rf_we, 0);
    resetn = 1'b1;
    tick();

    // Watchdog: divide stuck in DIV_BUSY for longer than 64 cycles
    offer(OP_DIV, 8, 2, 5'd4, 1'b1, 32'h304);
    tick();
    ds_to_es_valid = 1'b0;
    pulses = 0;
    repeat (80) begin
      settle();
      if (div_timeout === 1'b1) pulses++;
      tick();
    end
    check("watchdog_pulses", pulses, 1);
    check("watchdog_still_busy", es_allowin, 0);
    div_valid = 1'b1;
    tick();
    div_valid = 1'b0;
    settle();
    check("watchdog_result", es_result, 4);
    tick();

    // Randomized ALU traffic against an occupancy-level model
    occ = 1'b0;
    m_res = '0; m_pc = '0; m_dest = '0;
    for (int i = 0; i < 400; i++) begin
      int k;
      logic [31:0] a, b;
      logic [15:0] op;
      k  = $urandom_range(0, 2);
      op = (k == 0) ? OP_ADD : (k == 1) ? OP_SUB : OP_OR;
      a  = $urandom;
      b  = $urandom;
      offer(op, a, b, 5'($urandom_range(0, 31)), 1'b1, 32'($urandom));
      ds_to_es_valid = ($urandom_range(0, 3) != 0);
      ms_allowin     = ($urandom_range(0, 3) != 0);
      settle();
      allow_exp = !occ || ms_allowin;
      check("rnd_allowin", es_allowin, allow_exp);
      check("rnd_valid", es_to_ms_valid, occ);
      if (occ) begin
        check("rnd_result", es_result, m_res);
        check("rnd_dest", es_dest, m_dest);
        check("rnd_pc", es_pc, m_pc);
      end
      if (ds_to_es_valid && allow_exp) begin
        occ    = 1'b1;
        m_res  = ref_alu(op, a, b);
        m_dest = ds_dest;
        m_pc   = ds_pc;
      end else if (occ && ms_allowin) begin
        occ = 1'b0;
      end
      tick();
    end
    ds_to_es_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
